// File: rtl/tank_access_ctrl.sv
// Serial access sequencer for one mercury-tank store: tracks the circulating head
// position and gates exactly one long word into or out of the tank per request.
module tank_access_ctrl #(
  parameter  int STORE_LEN  = 16,
  parameter  int WORD_WIDTH = 36,
  parameter  int AW         = $clog2(STORE_LEN),
  localparam int BW         = $clog2(WORD_WIDTH)
) (
  input  logic                  rack_clk,
  input  logic                  rack_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AW-1:0]         req_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [AW-1:0]         pos_word,
  output logic [BW-1:0]         pos_bit,
  output logic                  rack_mib,
  output logic                  rack_loc_t_in,
  output logic                  rack_loc_t_clr,
  output logic                  rack_loc_t_out,
  input  logic                  rack_loc_mob_t
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(STORE_LEN - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);
  localparam logic [AW:0]   LEN_EXT   = (AW+1)'(STORE_LEN);

  state_t                r_state;
  logic                  r_ready, r_done, r_err;
  logic                  r_mib, r_t_in, r_t_clr, r_t_out;
  logic                  r_write;
  logic [AW-1:0]         r_addr, r_pos_word;
  logic [BW-1:0]         r_pos_bit;
  logic [WORD_WIDTH-1:0] r_wdata, r_cap, r_rd_data;

  logic [AW-1:0]         w_nxt_word;
  logic [BW-1:0]         w_nxt_bit;
  logic                  w_bit_wrap, w_oor, w_hit_req, w_hit_cur;
  logic [WORD_WIDTH-1:0] w_cap_nxt;

  // Strobes are registered, so every decision looks at the head position of the next cycle.
  assign w_bit_wrap = (r_pos_bit == LAST_BIT);
  assign w_nxt_bit  = w_bit_wrap ? '0 : r_pos_bit + BW'(1);
  assign w_nxt_word = !w_bit_wrap ? r_pos_word :
                      (r_pos_word == LAST_WORD) ? '0 : r_pos_word + AW'(1);
  assign w_oor      = ({1'b0, req_addr} >= LEN_EXT);
  assign w_hit_req  = (w_nxt_word == req_addr) && (w_nxt_bit == '0);
  assign w_hit_cur  = (w_nxt_word == r_addr)   && (w_nxt_bit == '0);

  always_comb begin
    w_cap_nxt            = r_cap;
    w_cap_nxt[r_pos_bit] = rack_loc_mob_t;
  end

  always_ff @(posedge rack_clk or negedge rack_rst_n) begin
    if (!rack_rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mib      <= 1'b0;
      r_t_in     <= 1'b0;
      r_t_clr    <= 1'b0;
      r_t_out    <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_pos_word <= '0;
      r_pos_bit  <= '0;
      r_wdata    <= '0;
      r_cap      <= '0;
      r_rd_data  <= '0;
    end else begin
      r_pos_word <= w_nxt_word;
      r_pos_bit  <= w_nxt_bit;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mib      <= 1'b0;
      r_t_in     <= 1'b0;
      r_t_clr    <= 1'b0;
      r_t_out    <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= wr_data;
          r_ready <= 1'b0;
          if (w_oor) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else if (w_hit_req) begin
            r_state <= S_XFER;
            r_t_in  <= req_write;
            r_t_clr <= req_write;
            r_t_out <= !req_write;
            r_mib   <= req_write & wr_data[0];
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: if (w_hit_cur) begin
          r_state <= S_XFER;
          r_t_in  <= r_write;
          r_t_clr <= r_write;
          r_t_out <= !r_write;
          r_mib   <= r_write & r_wdata[0];
        end
        S_XFER: begin
          r_cap <= w_cap_nxt;
          if (w_bit_wrap) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (!r_write) r_rd_data <= w_cap_nxt;
          end else begin
            r_t_in  <= r_write;
            r_t_clr <= r_write;
            r_t_out <= !r_write;
            r_mib   <= r_write & r_wdata[w_nxt_bit];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = r_ready;
  assign done           = r_done;
  assign err            = r_err;
  assign rd_data        = r_rd_data;
  assign pos_word       = r_pos_word;
  assign pos_bit        = r_pos_bit;
  assign rack_mib       = r_mib;
  assign rack_loc_t_in  = r_t_in;
  assign rack_loc_t_clr = r_t_clr;
  assign rack_loc_t_out = r_t_out;

endmodule

// File: tb/tb_tank_access_ctrl.sv
// Directed bench for tank_access_ctrl with a behavioural tank model and independent head counter.
module tb_tank_access_ctrl;
  localparam int SL = 16, WW = 36, AW = 4, BW = 6, P = SL * WW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic          req_ready, done, err, mib, t_in, t_clr, t_out, mob;
  logic [WW-1:0] rd_data;
  logic [AW-1:0] pos_word;
  logic [BW-1:0] pos_bit;

  logic          req_valid2 = 1'b0;
  logic [AW-1:0] req_addr2 = '0;
  logic          req_ready2, done2, err2, mib2, t_in2, t_clr2, t_out2;
  logic [WW-1:0] rd_data2;
  logic [AW-1:0] pos_word2;
  logic [BW-1:0] pos_bit2;

  always #5 clk = ~clk;

  tank_access_ctrl #(.STORE_LEN(SL), .WORD_WIDTH(WW)) dut (
    .rack_clk(clk), .rack_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wr_data(wr_data), .rd_data(rd_data),
    .done(done), .err(err), .pos_word(pos_word), .pos_bit(pos_bit), .rack_mib(mib),
    .rack_loc_t_in(t_in), .rack_loc_t_clr(t_clr), .rack_loc_t_out(t_out), .rack_loc_mob_t(mob));

  tank_access_ctrl #(.STORE_LEN(12), .WORD_WIDTH(WW)) dut2 (
    .rack_clk(clk), .rack_rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(1'b0), .req_addr(req_addr2), .wr_data('0), .rd_data(rd_data2),
    .done(done2), .err(err2), .pos_word(pos_word2), .pos_bit(pos_bit2), .rack_mib(mib2),
    .rack_loc_t_in(t_in2), .rack_loc_t_clr(t_clr2), .rack_loc_t_out(t_out2), .rack_loc_mob_t(1'b1));

  // Reference head position and tank contents.
  int            tb_h;
  logic          tank_ld = 1'b1;
  logic [WW-1:0] tank [SL];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_h <= 0;
    else        tb_h <= (tb_h + 1) % P;

  always @(posedge clk)
    if (tank_ld) for (int i = 0; i < SL; i++) tank[i] <= 36'h1_2345_6780 + WW'(i);
    else if (t_in && t_clr) tank[tb_h / WW][tb_h % WW] <= mib;

  assign mob = t_out ? tank[tb_h / WW][tb_h % WW] : 1'b1;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int            done_k, first_k, in_cnt, clr_cnt, out_cnt, pos_bad;
  logic          err_s;
  logic [WW-1:0] mib_w;

  task automatic run_op(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                        input int h, input int budget);
    for (int i = 0; i < P && tb_h != (h + P - 1) % P; i++) @(negedge clk);
    chk("ready_before", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; wr_data = d;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    done_k = -1; first_k = -1; in_cnt = 0; clr_cnt = 0; out_cnt = 0; pos_bad = 0;
    err_s = 1'b0; mib_w = '0;
    for (int k = 0; k <= budget; k++) begin
      if (t_in)  in_cnt++;
      if (t_clr) clr_cnt++;
      if (t_out) out_cnt++;
      if ((t_in || t_clr || t_out) && first_k < 0) first_k = k;
      if (t_in) mib_w[tb_h % WW] = mib;
      if (int'(pos_word) * WW + int'(pos_bit) != tb_h) pos_bad++;
      if (done) begin done_k = k; err_s = err; break; end
      @(negedge clk);
    end
    @(negedge clk);
    chk("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    @(posedge clk); #1 tank_ld = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_outs", {58'd0, done, err, mib, t_in, t_clr, t_out}, 64'd0);
    chk("rst_pos", {54'd0, pos_word, pos_bit}, 64'd0);
    chk("rst_rd", {28'd0, rd_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk); chk("pos_inc1", {54'd0, pos_word, pos_bit}, 64'd1);
    @(negedge clk); chk("pos_inc2", {54'd0, pos_word, pos_bit}, 64'd2);

    // write addr 3 with h=0
    run_op(1'b1, 4'd3, 36'h5_A5A5_A5A5, 0, 700);
    chk("wr_first", 64'(first_k), 64'd108);
    chk("wr_done", 64'(done_k), 64'd144);
    chk("wr_in_clr", {32'(in_cnt), 32'(clr_cnt)}, {32'd36, 32'd36});
    chk("wr_out", 64'(out_cnt), 64'd0);
    chk("wr_mib", {28'd0, mib_w}, {28'd0, 36'h5_A5A5_A5A5});
    chk("wr_err", {63'd0, err_s}, 64'd0);
    chk("wr_pos", 64'(pos_bad), 64'd0);

    // read back addr 3, h=200 -> wait 484
    run_op(1'b0, 4'd3, '0, 200, 700);
    chk("rd_first", 64'(first_k), 64'd484);
    chk("rd_done", 64'(done_k), 64'd520);
    chk("rd_out", 64'(out_cnt), 64'd36);
    chk("rd_noclr", {32'(in_cnt), 32'(clr_cnt)}, 64'd0);
    chk("rd_data", {28'd0, rd_data}, {28'd0, 36'h5_A5A5_A5A5});
    chk("rd_err", {63'd0, err_s}, 64'd0);

    // zero wait: addr 5, h=180
    run_op(1'b0, 4'd5, '0, 180, 700);
    chk("zw_first", 64'(first_k), 64'd0);
    chk("zw_done", 64'(done_k), 64'd36);
    chk("zw_data", {28'd0, rd_data}, {28'd0, 36'h1_2345_6785});

    // maximum wait: addr 5, h=181, crosses word 15 -> 0
    run_op(1'b0, 4'd5, '0, 181, 700);
    chk("mw_first", 64'(first_k), 64'd575);
    chk("mw_done", 64'(done_k), 64'd611);
    chk("mw_data", {28'd0, rd_data}, {28'd0, 36'h1_2345_6785});
    chk("mw_pos", 64'(pos_bad), 64'd0);

    // reset 10 cycles into a write XFER of addr 7 (zero wait)
    for (int i = 0; i < P && tb_h != 251; i++) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; wr_data = 36'hF_0000_FFFF;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_in", {62'd0, t_in, t_clr}, 64'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_strobes", {59'd0, mib, t_in, t_clr, t_out, done}, 64'd0);
    chk("mid_pos", {54'd0, pos_word, pos_bit}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel", {53'd0, req_ready, pos_word, pos_bit}, {53'd0, 1'b1, 10'd0});

    // STORE_LEN=12 instance: read word 0 (tank output tied high), then out-of-range
    @(negedge clk);
    req_valid2 = 1'b1; req_addr2 = 4'd0;
    @(posedge clk); #1 req_valid2 = 1'b0;
    done_k = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done2) begin done_k = k; break; end
    end
    chk("d2_rd_seen", {63'd0, done_k >= 0}, 64'd1);
    chk("d2_rd_data", {28'd0, rd_data2}, {28'd0, 36'hF_FFFF_FFFF});
    @(negedge clk);
    req_valid2 = 1'b1; req_addr2 = 4'd13;
    @(posedge clk); #1 req_valid2 = 1'b0;
    @(negedge clk);
    chk("oor_done_err", {62'd0, done2, err2}, 64'd3);
    chk("oor_strobes", {60'd0, mib2, t_in2, t_clr2, t_out2}, 64'd0);
    chk("oor_rd", {28'd0, rd_data2}, {28'd0, 36'hF_FFFF_FFFF});
    @(negedge clk);
    chk("oor_after", {61'd0, done2, err2, req_ready2}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
